// File: rtl/input_conditioner.sv
// Per-bit two-flop synchroniser followed by a counting debouncer with
// registered clean levels and one-cycle rise/fall edge pulses.
module input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0]            sync1_q;
    logic [WIDTH-1:0]            sync2_q;
    logic [WIDTH-1:0]            level_q;
    logic [WIDTH-1:0]            level_d;
    logic [WIDTH-1:0]            rise_q;
    logic [WIDTH-1:0]            rise_d;
    logic [WIDTH-1:0]            fall_q;
    logic [WIDTH-1:0]            fall_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

    // A bit only changes level after DEBOUNCE_CYCLES consecutive evaluated
    // cycles of disagreement; any agreeing cycle throws the partial count away.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = '0;
        fall_d  = '0;
        if (ena) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (sync2_q[b] == level_q[b]) begin
                    cnt_d[b] = '0;
                end else if (cnt_q[b] == CNT_LAST) begin
                    level_d[b] = sync2_q[b];
                    cnt_d[b]   = '0;
                    rise_d[b]  = sync2_q[b];
                    fall_d[b]  = ~sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_ONE;
                end
            end
        end
    end

    // The synchroniser runs regardless of ena so it is settled when ena returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_out = level_q;
    assign rise_out  = rise_q;
    assign fall_out  = fall_q;

endmodule
